pin_reader: RTL and testbench
=============================

PIN_READER -- requirements
Module: pin_reader

Interface
REQ-001 SHALL have parameter INVERT, default 1, meaning the pin carries inverted data; 1 = de-invert the sampled pin, 0 = pass through.
REQ-002 SHALL have parameter DEBOUNCE, default 4, legal 1..255, meaning the consecutive cycles a changed sample must persist before it is accepted.
REQ-003 SHALL have parameter CNT_W, default 8, meaning the edge_count width.
REQ-004 SHALL have port clock, input, 1, the single rising-edge clock for all state.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pin, input, 1, asynchronous external pin, registered and inverted by its driver.
REQ-007 SHALL have port clear, input, 1, synchronous clear of edge_count and overflow.
REQ-008 SHALL have port evt_ready, input, 1, consumer accepts the event.
REQ-009 SHALL have port level, output, 1, debounced, de-inverted pin value.
REQ-010 SHALL have port evt_valid, output, 1, event buffer holds an unconsumed level change.
REQ-011 SHALL have port evt_rise, output, 1, buffered event direction: 1 = level went 0->1, 0 = level went 1->0.
REQ-012 SHALL have port overflow, output, 1, sticky flag for a dropped event.
REQ-013 SHALL have port edge_count, output, CNT_W, count of accepted level changes.

Function
REQ-014 SHALL sample pin through two flip-flops s1->s2; d = s2 XOR INVERT.
REQ-015 SHALL hold an 8-bit debounce counter: cleared when d == level; incremented when d != level.
REQ-016 SHALL load level <= d and clear the counter on the edge where d != level and counter == DEBOUNCE-1.
REQ-017 SHALL give latency from a clean pin change to level change of exactly DEBOUNCE+2 rising edges, counting the first edge that samples the new pin value.
REQ-018 SHALL reject any glitch shorter than DEBOUNCE cycles at d: level is unchanged and the counter restarts from 0.
REQ-019 SHALL define an accepted change as the cycle level is loaded with a new value, producing event E with direction = new level.
REQ-020 SHALL load E into the single-entry buffer (evt_valid=1, evt_rise=new level) when evt_valid==0, or when evt_valid && evt_ready in the same cycle.
REQ-021 SHALL, when evt_valid && !evt_ready at E, drop E, keep the buffer unchanged, and set overflow=1.
REQ-022 SHALL clear evt_valid on evt_valid && evt_ready when no E occurs in that cycle.
REQ-023 SHALL hold evt_rise stable while evt_valid==1 && evt_ready==0.
REQ-024 SHALL increment edge_count on every E, including dropped events, and wrap from 2^CNT_W-1 to 0.
REQ-025 SHALL, on clear, set edge_count=0 and overflow=0.
REQ-026 SHALL give E precedence when clear and E occur in the same cycle: edge_count=1, and overflow=1 if that E is dropped.
REQ-027 SHALL make clear leave level, the event buffer and the debounce counter unaffected.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set s1=s2=0, level=INVERT, debounce counter=0, evt_valid=0, evt_rise=0, overflow=0, edge_count=0.
REQ-029 SHALL produce no event from reset release alone; with pin=0, INVERT=1, no event occurs after release.
REQ-030 SHALL make reset asserted mid-debounce or with evt_valid=1 discard all pending state immediately.

Verification
REQ-031 SHALL cover clean edge: INVERT=1, DEBOUNCE=4, pin held 0, then set to 1 -> level 1->0 on the 6th edge; evt_valid=1, evt_rise=0, edge_count=1.
REQ-032 SHALL cover glitch: pin pulsed for 3 cycles with DEBOUNCE=4 -> no level change, evt_valid stays 0, edge_count stays 0.
REQ-033 SHALL cover overflow: evt_ready=0, two accepted changes -> first event held with evt_rise unchanged, overflow=1, edge_count=2; then evt_ready=1 for one cycle -> evt_valid=0.
REQ-034 SHALL cover back-to-back: evt_ready=1 constantly, DEBOUNCE=1, pin toggled every 4 cycles -> one evt_valid pulse per change, overflow stays 0.
REQ-035 SHALL cover clear collision: clear asserted in the same cycle as E with CNT_W=8 and edge_count=255 -> edge_count=1; separately, increment from 255 with no clear -> edge_count=0.
REQ-036 SHALL cover reset mid-debounce: reset_n pulsed low with the counter at 2 -> all outputs at reset values; no event after release while pin is steady.

Source files
------------

// File: rtl/pin_reader.sv
// Pin reader: synchronises an inverted external pin, debounces it, and
// reports each accepted level change through a single-entry event buffer.
module pin_reader #(
  parameter bit          INVERT   = 1'b1,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pin,
  input  logic             clear,
  input  logic             evt_ready,
  output logic             level,
  output logic             evt_valid,
  output logic             evt_rise,
  output logic             overflow,
  output logic [CNT_W-1:0] edge_count
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  logic       s1;
  logic       s2;
  logic       d;
  logic [7:0] db_cnt;
  logic       accept;
  logic       drop;

  assign d      = s2 ^ INVERT;
  assign accept = (d != level) && (db_cnt == DB_LAST);
  assign drop   = accept && evt_valid && !evt_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      level  <= INVERT;
      db_cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (d == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level  <= d;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid <= 1'b0;
      evt_rise  <= 1'b0;
    end else if (accept && (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_rise  <= d;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  // An event in the same cycle as clear wins: it counts as the first edge
  // after the clear, and a dropped one re-arms overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        edge_count <= clear ? CNT_W'(1) : edge_count + 1'b1;
      end else if (clear) begin
        edge_count <= '0;
      end
      if (clear) begin
        overflow <= drop;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pin_reader.sv
// Directed bench for pin_reader: default instance plus a DEBOUNCE=1 instance.
module tb_pin_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pin;
  logic       clear;
  logic       evt_ready;
  logic       level;
  logic       evt_valid;
  logic       evt_rise;
  logic       overflow;
  logic [7:0] edge_count;

  logic       f_pin;
  logic       f_clear;
  logic       f_ready;
  logic       f_level;
  logic       f_valid;
  logic       f_rise;
  logic       f_ov;
  logic [7:0] f_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  pin_reader u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pin        (pin),
    .clear      (clear),
    .evt_ready  (evt_ready),
    .level      (level),
    .evt_valid  (evt_valid),
    .evt_rise   (evt_rise),
    .overflow   (overflow),
    .edge_count (edge_count)
  );

  pin_reader #(.INVERT(1'b1), .DEBOUNCE(1), .CNT_W(8)) u_fast (
    .clock      (clock),
    .reset_n    (reset_n),
    .pin        (f_pin),
    .clear      (f_clear),
    .evt_ready  (f_ready),
    .level      (f_level),
    .evt_valid  (f_valid),
    .evt_rise   (f_rise),
    .overflow   (f_ov),
    .edge_count (f_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic toggle;
    pin = ~pin;
    repeat (8) tick();
  endtask

  initial begin
    int unsigned pulses;
    reset_n   = 1'b0;
    pin       = 1'b0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    f_pin     = 1'b0;
    f_clear   = 1'b0;
    f_ready   = 1'b1;
    repeat (2) tick();
    check("rst_level", level, 1);
    check("rst_valid", evt_valid, 0);
    check("rst_rise", evt_rise, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", edge_count, 0);
    reset_n = 1'b1;
    repeat (10) tick();
    check("release_valid", evt_valid, 0);
    check("release_count", edge_count, 0);
    check("release_level", level, 1);

    // Back-to-back on the DEBOUNCE=1 instance: one valid pulse per change
    for (int i = 0; i < 6; i++) begin
      f_pin  = ~f_pin;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (f_valid) pulses++;
      end
      check("fast_pulse", pulses, 1);
    end
    check("fast_ovf", f_ov, 0);
    check("fast_count", f_count, 6);
    check("fast_level", f_level, 1);

    // Three-cycle glitch is rejected
    pin = 1'b1;
    repeat (3) tick();
    pin = 1'b0;
    repeat (10) tick();
    check("glitch_level", level, 1);
    check("glitch_valid", evt_valid, 0);
    check("glitch_count", edge_count, 0);

    // Clean edge: level falls on the sixth edge
    pin = 1'b1;
    repeat (5) tick();
    check("clean_pre_level", level, 1);
    tick();
    check("clean_level", level, 0);
    check("clean_valid", evt_valid, 1);
    check("clean_rise", evt_rise, 0);
    check("clean_count", edge_count, 1);

    // Second change while buffer is full is dropped
    repeat (4) tick();
    pin = 1'b0;
    repeat (6) tick();
    check("ovf_level", level, 1);
    check("ovf_valid", evt_valid, 1);
    check("ovf_rise", evt_rise, 0);
    check("ovf_flag", overflow, 1);
    check("ovf_count", edge_count, 2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("ovf_drain", evt_valid, 0);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count", edge_count, 0);
    check("clear_ovf", overflow, 0);
    check("clear_level", level, 1);

    evt_ready = 1'b1;
    repeat (255) toggle();
    check("count_255", edge_count, 255);

    // Clear on the same edge as an accepted event
    evt_ready = 1'b0;
    pin = ~pin;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("coll_count", edge_count, 1);
    check("coll_ovf", overflow, 0);
    check("coll_valid", evt_valid, 1);
    check("coll_rise", evt_rise, 1);

    repeat (2) tick();
    pin = ~pin;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("colldrop_count", edge_count, 1);
    check("colldrop_ovf", overflow, 1);
    check("colldrop_rise", evt_rise, 1);
    evt_ready = 1'b1;
    tick();
    check("colldrop_drain", evt_valid, 0);

    repeat (254) toggle();
    check("prewrap_count", edge_count, 255);
    toggle();
    check("wrap_count", edge_count, 0);
    check("wrap_ovf_sticky", overflow, 1);

    // Reset with the debounce counter at 2 and an event pending
    evt_ready = 1'b0;
    pin = 1'b1;
    repeat (8) tick();
    check("pend_valid", evt_valid, 1);
    pin = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_level", level, 1);
    check("midrst_valid", evt_valid, 0);
    check("midrst_rise", evt_rise, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_count", edge_count, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (12) tick();
    check("postrst_level", level, 1);
    check("postrst_valid", evt_valid, 0);
    check("postrst_count", edge_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
